// File: rtl/aes_pkg.sv
// aes_pkg: shared AES byte/word/state types plus the ShiftRows helpers
// (NB legality, buffer depth legality, per-row offsets, source column).
package aes_pkg;

    typedef logic [7:0]  aes_byte_t;
    typedef logic [31:0] aes_word_t;

    localparam int unsigned AES_ROWS = 4;

    // Only the Rijndael block sizes 128/192/256 bits are supported.
    function automatic bit nb_is_legal(input int unsigned nb);
        return (nb == 4) || (nb == 6) || (nb == 8);
    endfunction

    function automatic bit depth_is_legal(input int unsigned d);
        return (d >= 2) && ((d & (d - 1)) == 0);
    endfunction

    // Rijndael shift offsets: rows 2/3 shift further for 256-bit blocks.
    function automatic int unsigned row_offset(
        input int unsigned nb,
        input int unsigned row
    );
        int unsigned off;
        case (row)
            0:       off = 0;
            1:       off = 1;
            2:       off = (nb == 8) ? 3 : 2;
            default: off = (nb == 8) ? 4 : 3;
        endcase
        return off;
    endfunction

    // Column of the input byte that lands in (row, col) of the result.
    function automatic int unsigned src_col(
        input int unsigned nb,
        input int unsigned row,
        input int unsigned col,
        input bit          inv
    );
        int unsigned off;
        off = row_offset(nb, row);
        if (inv) begin
            return (col + nb - off) % nb;
        end
        return (col + off) % nb;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// shift_rows_perm: purely combinational (Inv)ShiftRows byte permutation.
// Ports: in_data state in, inv selects inverse, out_data permuted state.
import aes_pkg::*;

module shift_rows_perm #(
    parameter int NB = 4
) (
    input  logic [0:32*NB-1] in_data,
    input  logic             inv,
    output logic [0:32*NB-1] out_data
);

    // Byte k sits at bits [8k +: 8]; row = k % 4, column = k / 4.
    for (genvar c = 0; c < NB; c++) begin : g_col
        for (genvar r = 0; r < AES_ROWS; r++) begin : g_row
            localparam int unsigned FWD = src_col(NB, r, c, 1'b0);
            localparam int unsigned INV = src_col(NB, r, c, 1'b1);
            localparam int unsigned DST = 8 * (4 * c + r);
            localparam int unsigned SRF = 8 * (4 * FWD + r);
            localparam int unsigned SRI = 8 * (4 * INV + r);

            assign out_data[DST +: 8] = inv ? in_data[SRI +: 8]
                                            : in_data[SRF +: 8];
        end
    end

endmodule

// File: rtl/shift_rows_stream.sv
// shift_rows_stream: ShiftRows/InvShiftRows on a valid/ready stream with a
// DEPTH-entry result FIFO. Ports: clk, rst_n (async low), flush; in_valid/
// in_ready/in_inv/in_data; out_valid/out_ready/out_data; level occupancy.
import aes_pkg::*;

module shift_rows_stream #(
    parameter int NB    = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inv,
    input  logic [0:32*NB-1]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [0:32*NB-1]       out_data,
    output logic [$clog2(DEPTH):0] level
);

    localparam int W  = 32 * NB;
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    if (!nb_is_legal(NB)) begin : g_bad_nb
        $error("shift_rows_stream: NB must be 4, 6 or 8");
    end

    if (!depth_is_legal(DEPTH)) begin : g_bad_depth
        $error("shift_rows_stream: DEPTH must be a power of 2, >= 2");
    end

    logic [0:W-1]    perm_data;
    logic [0:W-1]    mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW-1:0]   rd_ptr_d;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;

    shift_rows_perm #(
        .NB(NB)
    ) u_perm (
        .in_data (in_data),
        .inv     (in_inv),
        .out_data(perm_data)
    );

    assign full  = (level_q == LW'(DEPTH));
    assign empty = (level_q == '0);

    // rst_n gates ready so nothing is offered while reset is held.
    // Full blocks push even if a pop happens on the same edge.
    assign in_ready  = rst_n && !full && !flush;
    assign out_valid = !empty;
    assign out_data  = mem_q[rd_ptr_q];
    assign level     = level_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_d = level_q + LW'(1);
                2'b01:   level_d = level_q - LW'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage is cleared on reset only so out_data never shows X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= perm_data;
        end
    end

endmodule

// File: tb/tb_shift_rows_stream.sv
// tb_shift_rows_stream: scoreboard bench for shift_rows_stream at NB=4 and
// NB=8 with directed vectors, backpressure, flush/reset and random traffic.
module tb_shift_rows_stream;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         flush4 = 0, in_valid4 = 0, in_inv4 = 0, out_ready4 = 0;
    logic         in_ready4, out_valid4;
    logic [0:127] in_data4 = '0;
    logic [0:127] out_data4;
    logic [2:0]   level4;

    logic         flush8 = 0, in_valid8 = 0, in_inv8 = 0, out_ready8 = 0;
    logic         in_ready8, out_valid8;
    logic [0:255] in_data8 = '0;
    logic [0:255] out_data8;
    logic [2:0]   level8;

    shift_rows_stream #(.NB(4), .DEPTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush4),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .in_inv(in_inv4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .out_data(out_data4), .level(level4)
    );

    shift_rows_stream #(.NB(8), .DEPTH(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .flush(flush8),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .in_inv(in_inv8), .in_data(in_data8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .out_data(out_data8), .level(level8)
    );

    int n_checks = 0;
    int n_fail = 0;
    int acc4 = 0, acc8 = 0, pop4 = 0, pop8 = 0;
    logic [0:255] q4[$];
    logic [0:255] q8[$];

    task automatic chk(input string nm, input logic [0:255] act,
                       input logic [0:255] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_v(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: state as a 4 x nb byte grid, rows rotated by their offset.
    function automatic logic [0:255] model(input logic [0:255] d,
                                           input logic inv, input int nb);
        logic [0:255] o;
        int off[4];
        int src;
        o = '0;
        off[0] = 0;
        off[1] = 1;
        off[2] = (nb == 8) ? 3 : 2;
        off[3] = (nb == 8) ? 4 : 3;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < nb; c++) begin
                if (inv) src = (c - off[r] + nb) % nb;
                else     src = (c + off[r]) % nb;
                o[8*(4*c+r) +: 8] = d[8*(4*src+r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [0:255] rnd256();
        logic [0:255] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Expected results are queued when a beat is accepted.
    always @(negedge clk) begin
        if (rst_n) begin
            if (flush4) q4.delete();
            else if (in_valid4 && in_ready4) begin
                q4.push_back(model({in_data4, 128'h0}, in_inv4, 4));
                acc4++;
            end
            if (flush8) q8.delete();
            else if (in_valid8 && in_ready8) begin
                q8.push_back(model(in_data8, in_inv8, 8));
                acc8++;
            end
        end
    end

    always @(negedge rst_n) begin
        q4.delete();
        q8.delete();
    end

    // Monitor: pops and compares whenever the DUT hands over a result.
    logic         hold8 = 0;
    logic [0:255] held8;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold8 = 0;
        end else begin
            if (!flush4 && out_valid4 && out_ready4) begin
                pop4++;
                if (q4.size() == 0) chk("sb4_unexpected", {out_data4, 128'h0}, '1);
                else chk("sb4_data", {out_data4, 128'h0}, q4.pop_front());
            end
            if (hold8) begin
                chk_v("hold8_valid", 32'(out_valid8), 32'd1);
                chk("hold8_data", out_data8, held8);
            end
            if (!flush8 && out_valid8 && out_ready8) begin
                pop8++;
                if (q8.size() == 0) chk("sb8_unexpected", out_data8, '1);
                else chk("sb8_data", out_data8, q8.pop_front());
            end
            hold8 = out_valid8 && !out_ready8;
            held8 = out_data8;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic [0:127] d, input logic inv);
        in_valid4 = 1;
        in_data4 = d;
        in_inv4 = inv;
        tick();
        in_valid4 = 0;
    endtask

    task automatic drain4();
        int n;
        n = 0;
        out_ready4 = 1;
        while (level4 != 0 && n < 50) begin
            tick();
            n++;
        end
        out_ready4 = 0;
        chk_v("drain4_level", 32'(level4), 32'd0);
    endtask

    logic [0:255] r;
    int a0, p0, n;

    initial begin
        #12;
        chk_v("rst_in_ready4", 32'(in_ready4), 32'd0);
        chk_v("rst_out_valid4", 32'(out_valid4), 32'd0);
        chk_v("rst_level4", 32'(level4), 32'd0);
        chk_v("rst_in_ready8", 32'(in_ready8), 32'd0);
        chk_v("rst_level8", 32'(level8), 32'd0);
        @(negedge clk);
        rst_n = 1;
        tick();
        chk_v("post_rst_in_ready4", 32'(in_ready4), 32'd1);
        chk_v("post_rst_level4", 32'(level4), 32'd0);

        push4(128'h0123456789abcdef0123456789abcdef, 1'b0);
        chk_v("v031_valid", 32'(out_valid4), 32'd1);
        chk_v("v031_level", 32'(level4), 32'd1);
        chk("v031_data", {out_data4, 128'h0},
            {128'h01ab45ef8923cd6701ab45ef8923cd67, 128'h0});
        drain4();

        push4(128'hd42711aee0bf98f1b8b45de51e415230, 1'b0);
        chk("fips_fwd", {out_data4, 128'h0},
            {128'hd4bf5d30e0b452aeb84111f11e2798e5, 128'h0});
        drain4();
        push4(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1);
        chk("fips_inv", {out_data4, 128'h0},
            {128'hd42711aee0bf98f1b8b45de51e415230, 128'h0});
        drain4();

        a0 = acc4;
        for (int i = 0; i < 5; i++) begin
            r = rnd256();
            push4(r[0:127], 1'($urandom_range(0, 1)));
        end
        chk_v("bp_accepted", 32'(acc4 - a0), 32'd4);
        chk_v("bp_level", 32'(level4), 32'd4);
        chk_v("bp_in_ready", 32'(in_ready4), 32'd0);
        p0 = pop4;
        drain4();
        chk_v("bp_popped", 32'(pop4 - p0), 32'd4);

        for (int i = 0; i < 4; i++) begin
            r = rnd256();
            push4(r[0:127], 1'($urandom_range(0, 1)));
        end
        chk_v("full_level", 32'(level4), 32'd4);
        r = rnd256();
        in_valid4 = 1;
        in_data4 = r[0:127];
        out_ready4 = 1;
        tick();
        chk_v("full_pop_level", 32'(level4), 32'd3);
        chk_v("full_pop_in_ready", 32'(in_ready4), 32'd1);
        out_ready4 = 0;
        tick();
        in_valid4 = 0;
        chk_v("full_push_level", 32'(level4), 32'd4);
        drain4();

        for (int i = 0; i < 3; i++) begin
            r = rnd256();
            push4(r[0:127], 1'b0);
        end
        chk_v("fl_level3", 32'(level4), 32'd3);
        flush4 = 1;
        in_valid4 = 1;
        #1;
        chk_v("fl_in_ready", 32'(in_ready4), 32'd0);
        tick();
        flush4 = 0;
        in_valid4 = 0;
        chk_v("fl_level", 32'(level4), 32'd0);
        chk_v("fl_out_valid", 32'(out_valid4), 32'd0);
        tick();
        chk_v("fl_stays_empty", 32'(level4), 32'd0);

        for (int i = 0; i < 3; i++) begin
            r = rnd256();
            push4(r[0:127], 1'b1);
        end
        chk_v("rs_level3", 32'(level4), 32'd3);
        #2;
        rst_n = 0;
        #1;
        chk_v("rs_level", 32'(level4), 32'd0);
        chk_v("rs_out_valid", 32'(out_valid4), 32'd0);
        chk_v("rs_in_ready", 32'(in_ready4), 32'd0);
        @(negedge clk);
        #1;
        rst_n = 1;
        tick();
        chk_v("rs_post_in_ready", 32'(in_ready4), 32'd1);
        chk_v("rs_post_level", 32'(level4), 32'd0);

        a0 = acc4;
        p0 = pop4;
        n = 0;
        while (acc4 - a0 < 200 && n < 5000) begin
            r = rnd256();
            in_valid4 = ($urandom_range(0, 3) != 0);
            in_data4 = r[0:127];
            in_inv4 = 1'($urandom_range(0, 1));
            out_ready4 = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        in_valid4 = 0;
        drain4();
        chk_v("rnd4_accepted", 32'(acc4 - a0), 32'd200);
        chk_v("rnd4_popped", 32'(pop4 - p0), 32'd200);

        a0 = acc8;
        p0 = pop8;
        n = 0;
        while (acc8 - a0 < 1000 && n < 20000) begin
            in_valid8 = ($urandom_range(0, 3) != 0);
            in_data8 = rnd256();
            in_inv8 = 1'($urandom_range(0, 1));
            out_ready8 = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        in_valid8 = 0;
        out_ready8 = 1;
        n = 0;
        while (level8 != 0 && n < 50) begin
            tick();
            n++;
        end
        out_ready8 = 0;
        tick();
        chk_v("rnd8_accepted", 32'(acc8 - a0), 32'd1000);
        chk_v("rnd8_popped", 32'(pop8 - p0), 32'd1000);
        chk_v("rnd8_level", 32'(level8), 32'd0);
        chk_v("rnd8_sb_empty", 32'(q8.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/shift_rows_stream.md
SHIFT_ROWS_STREAM -- requirements
Module: shift_rows_stream

Interface
REQ-001 SHALL have parameter NB, default 4, meaning state columns (legal values 4, 6, 8); data width W = 32*NB.
REQ-002 SHALL have parameter DEPTH, default 4, meaning output buffer entries (power of 2, >= 2).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port flush  input  1  synchronous discard of all buffered results.
REQ-006 SHALL have port in_valid  input  1  input beat present.
REQ-007 SHALL have port in_ready  output  1  block accepts a beat this cycle.
REQ-008 SHALL have port in_inv  input  1  0 = ShiftRows, 1 = InvShiftRows, sampled per beat.
REQ-009 SHALL have port in_data  input  [0:W-1]  state; byte k = in_data[8k +: 8], row = k mod 4, column = k div 4.
REQ-010 SHALL have port out_valid  output  1  result available at buffer head.
REQ-011 SHALL have port out_ready  input  1  consumer takes head this cycle.
REQ-012 SHALL have port out_data  output  [0:W-1]  permuted state, same byte layout as in_data.
REQ-013 SHALL have port level  output  $clog2(DEPTH)+1  current buffer occupancy.

Function
REQ-014 Row shift offsets SHALL be (0,1,2,3) for NB=4 and NB=6, (0,1,3,4) for NB=8.
REQ-015 Forward: out[r][c] SHALL equal in[r][(c + off(r)) mod NB]; inverse: out[r][c] SHALL equal in[r][(c - off(r)) mod NB].
REQ-016 Push SHALL occur when in_valid && in_ready; permuted data written into buffer tail at that edge.
REQ-017 Pop SHALL occur when out_valid && out_ready; head advances at that edge.
REQ-018 in_ready SHALL equal (level < DEPTH) && !flush; no push while full, even with simultaneous pop.
REQ-019 out_valid SHALL equal (level != 0); out_data SHALL show head entry, don't-care content when empty but stable (no X after reset).
REQ-020 Latency SHALL be 1 cycle: beat pushed at edge k is visible on out_valid/out_data in the cycle following edge k; no combinational input-to-output path.
REQ-021 Simultaneous push and pop (not full, not empty) SHALL leave level unchanged and preserve FIFO order.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH nor underflow.
REQ-023 out_data/out_valid SHALL hold unchanged while out_valid && !out_ready.
REQ-024 in_inv SHALL be applied per beat; mixed-mode beats in the buffer SHALL each retain their own mode result.
REQ-025 flush SHALL take priority over push and pop: at the flush edge pointers and level return to 0, in-flight push and pop are discarded.

Reset
REQ-026 rst_n low SHALL asynchronously clear pointers and level to 0, out_valid to 0, in_ready to 0 while asserted; buffer storage need not be cleared.
REQ-027 Reset asserted mid-operation SHALL discard all buffered results; first edge after deassertion SHALL see in_ready = 1, level = 0.

Structure
REQ-028 Package aes_pkg SHALL hold byte/state typedefs, NB-legality check and the row-offset function.
REQ-029 Combinational permutation SHALL live in sub-module shift_rows_perm (parameters NB; ports in_data, inv, out_data); shift_rows_stream instantiates it once ahead of the buffer.
REQ-030 Illegal NB or non-power-of-2 DEPTH SHALL be rejected at elaboration.

Verification
REQ-031 NB=4 forward: in_data 0123456789abcdef0123456789abcdef -> out_data 01ab45ef8923cd6701ab45ef8923cd67 one cycle later.
REQ-032 NB=4 FIPS-197 round 1: d42711aee0bf98f1b8b45de51e415230 forward -> d4bf5d30e0b452aeb84111f11e2798e5; same output with in_inv=1 -> original input.
REQ-033 Backpressure: out_ready=0, push 5 beats at DEPTH=4 -> 4 accepted, in_ready=0, level=4; release out_ready -> 4 results in order, level back to 0.
REQ-034 Full with simultaneous pop: level=4, in_valid=1, out_ready=1 -> pop only, level=3; next cycle push accepted.
REQ-035 Flush/reset: level=3, assert flush with in_valid=1 -> level=0, out_valid=0 next cycle, beat dropped; repeat with rst_n pulse mid-stream -> same empty state.
REQ-036 NB=8 forward/inverse random round-trip of 1000 mixed-mode beats against software model with random out_ready; zero mismatches.
